// File: rtl/fetch_unit.sv
// Instruction-fetch front end: address generator, pipelined memory request port and a
// DEPTH-entry {pc, instr} prefetch FIFO with redirect flush and in-flight response dropping.
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  output logic                         mem_req,
  output logic [XLEN-1:0]              mem_addr,
  input  logic                         mem_gnt,
  input  logic                         mem_rvalid,
  input  logic [ILEN-1:0]              mem_rdata,
  output logic                         instr_valid,
  output logic [ILEN-1:0]              instr_data,
  output logic [XLEN-1:0]              instr_pc,
  input  logic                         instr_ready,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = CW + 1;

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] rpc;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [ILEN-1:0] data_mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [SW-1:0]   occupancy;
  logic            accept;
  logic            push;
  logic            pop;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Handshakes: a request transfers when mem_req && mem_gnt, an instruction transfers when
  // instr_valid && instr_ready; valid never depends on ready, and a redirect masks both.
  // Buffered plus outstanding fetches are capped at DEPTH so a response always has a free slot.
  assign occupancy   = SW'(count) + SW'(inflight);
  assign mem_req     = !RST && !redirect_valid && (occupancy < SW'(DEPTH));
  assign mem_addr    = fpc;
  assign accept      = mem_req && mem_gnt;

  assign instr_valid = (count != '0) && !redirect_valid;
  assign instr_data  = data_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
  assign pop         = instr_valid && instr_ready;
  assign push        = mem_rvalid && !redirect_valid && (drop == '0);
  assign fifo_count  = count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old stream; a response landing now is lost too.
      fpc      <= {redirect_pc[XLEN-1:2], 2'b00};
      rpc      <= {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= inflight - CW'(mem_rvalid);
      drop     <= inflight - CW'(mem_rvalid);
    end else begin
      if (accept) fpc <= fpc + XLEN'(4);
      if (push) begin
        rpc    <= rpc + XLEN'(4);
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (mem_rvalid && (drop != '0)) drop <= drop - CW'(1);
      inflight <= inflight + CW'(accept) - CW'(mem_rvalid);
      count    <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      pc_mem[wr_ptr]   <= rpc;
      data_mem[wr_ptr] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table, directed redirect/stall/wrap sequences and a
// randomised phase, all checked against a queue of expected {pc, instr} deliveries.
module tb_fetch_unit;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int W    = XLEN + ILEN;

  logic            CLK = 1'b0;
  logic            RST;
  logic            mem_req, mem_req_w;
  logic [XLEN-1:0] mem_addr, mem_addr_w;
  logic            mem_gnt;
  logic            mem_rvalid, mem_rvalid_w;
  logic [ILEN-1:0] mem_rdata, mem_rdata_w;
  logic            instr_valid, instr_valid_w;
  logic [ILEN-1:0] instr_data, instr_data_w;
  logic [XLEN-1:0] instr_pc, instr_pc_w;
  logic            instr_ready, instr_ready_w;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_valid_w;
  logic [XLEN-1:0] redirect_pc_w;
  logic [2:0]      fifo_count, fifo_count_w;

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fifo_count(fifo_count)
  );

  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_w (
    .CLK(CLK), .RST(RST), .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid_w), .mem_rdata(mem_rdata_w), .instr_valid(instr_valid_w),
    .instr_data(instr_data_w), .instr_pc(instr_pc_w), .instr_ready(instr_ready_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w), .fifo_count(fifo_count_w)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int lat_lo = 1;
  int lat_hi = 1;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w_q[$];
  logic [95:0]  pend_q[$];
  logic [95:0]  pend_w_q[$];

  function automatic logic [ILEN-1:0] data_of(input logic [XLEN-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    mem_gnt = 1'b0;
    instr_ready = 1'b0;
    instr_ready_w = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    redirect_valid_w = 1'b0;
    redirect_pc_w = '0;
    mem_rvalid = 1'b0;
    mem_rvalid_w = 1'b0;
    mem_rdata = '0;
    mem_rdata_w = '0;
    exp_q.delete();
    exp_w_q.delete();
    pend_q.delete();
    pend_w_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    check("reset mem_req", W'(mem_req), W'(0));
    check("reset instr_valid", W'(instr_valid), W'(0));
    check("reset fifo_count", W'(fifo_count), W'(0));
    @(negedge CLK);
    RST = 1'b0;
    cyc = 0;
  endtask

  // One clock: scoreboard pops/pushes, memory model bookkeeping, then next-cycle responses.
  task automatic tick();
    logic a0, a1;
    logic [W-1:0] e;
    #1;
    a0 = mem_req && mem_gnt;
    a1 = mem_req_w && mem_gnt;
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) note_fail("sb0 pop with empty queue");
      else begin
        e = exp_q.pop_front();
        check("sb0 delivered {pc,instr}", {instr_pc, instr_data}, e);
      end
    end
    if (instr_valid_w && instr_ready_w) begin
      if (exp_w_q.size() == 0) note_fail("sb1 pop with empty queue");
      else begin
        e = exp_w_q.pop_front();
        check("sb1 delivered {pc,instr}", {instr_pc_w, instr_data_w}, e);
      end
    end
    if (redirect_valid) exp_q.delete();
    if (a0) begin
      exp_q.push_back({mem_addr, data_of(mem_addr)});
      pend_q.push_back({32'(cyc + $urandom_range(lat_hi, lat_lo)), mem_addr});
    end
    if (a1) begin
      exp_w_q.push_back({mem_addr_w, data_of(mem_addr_w)});
      pend_w_q.push_back({32'(cyc + $urandom_range(lat_hi, lat_lo)), mem_addr_w});
    end
    if (mem_rvalid) void'(pend_q.pop_front());
    if (mem_rvalid_w) void'(pend_w_q.pop_front());
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    if (pend_q.size() != 0 && int'(pend_q[0][95:64]) <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata = data_of(pend_q[0][63:0]);
    end
    mem_rvalid_w = 1'b0;
    mem_rdata_w = '0;
    if (pend_w_q.size() != 0 && int'(pend_w_q[0][95:64]) <= cyc) begin
      mem_rvalid_w = 1'b1;
      mem_rdata_w = data_of(pend_w_q[0][63:0]);
    end
  endtask

  typedef struct {
    logic            gnt;
    logic            ready;
    logic            exp_req;
    logic [XLEN-1:0] exp_addr;
    logic [2:0]      exp_count;
    logic            exp_valid;
    logic [XLEN-1:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic found;

    // fill from reset with latency 1, then a one-cycle pop frees a slot for 0x10
    vecs[0] = '{1'b1, 1'b0, 1'b1, 64'h00, 3'd0, 1'b0, 64'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 64'h04, 3'd0, 1'b0, 64'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 64'h08, 3'd1, 1'b1, 64'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 64'h0C, 3'd2, 1'b1, 64'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 64'h10, 3'd3, 1'b1, 64'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 64'h10, 3'd4, 1'b1, 64'h0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 64'h10, 3'd4, 1'b1, 64'h0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 64'h10, 3'd3, 1'b1, 64'h4};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 64'h14, 3'd3, 1'b1, 64'h4};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 64'h14, 3'd4, 1'b1, 64'h4};

    do_reset();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 10; i++) begin
      mem_gnt = vecs[i].gnt;
      instr_ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d mem_req", i), W'(mem_req), W'(vecs[i].exp_req));
      check($sformatf("vec%0d mem_addr", i), W'(mem_addr), W'(vecs[i].exp_addr));
      check($sformatf("vec%0d fifo_count", i), W'(fifo_count), W'(vecs[i].exp_count));
      check($sformatf("vec%0d instr_valid", i), W'(instr_valid), W'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d instr_pc", i), W'(instr_pc), W'(vecs[i].exp_pc));
      tick();
    end

    // redirect with two fetches outstanding at latency 3
    do_reset();
    lat_lo = 3; lat_hi = 3;
    mem_gnt = 1'b1;
    tick();
    tick();
    mem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h103;
    #1;
    check("t3 mem_req during redirect", W'(mem_req), W'(0));
    tick();
    redirect_valid = 1'b0;
    mem_gnt = 1'b1;
    #1;
    check("t3 mem_req after redirect", W'(mem_req), W'(1));
    check("t3 mem_addr after redirect", W'(mem_addr), W'(64'h100));
    tick();
    tick();
    #1;
    check("t3 count after two drops", W'(fifo_count), W'(0));
    check("t3 valid after two drops", W'(instr_valid), W'(0));
    mem_gnt = 1'b0;
    instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (instr_valid) found = 1'b1;
      else tick();
    end
    check("t3 first valid within bound", W'(found), W'(1));
    if (found) check("t3 first instr_pc", W'(instr_pc), W'(64'h100));
    repeat (6) tick();

    // redirect coinciding with a response and a pop attempt, then a second redirect
    do_reset();
    lat_lo = 1; lat_hi = 1;
    mem_gnt = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h203;
    instr_ready = 1'b1;
    #1;
    check("t4 instr_valid masked", W'(instr_valid), W'(0));
    check("t4 mem_req masked", W'(mem_req), W'(0));
    tick();
    redirect_pc = 64'h42;
    #1;
    check("t4 count after redirect", W'(fifo_count), W'(0));
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t4 last redirect wins", W'(mem_addr), W'(64'h40));
    repeat (8) tick();

    // grant withheld: address and fpc stay put
    do_reset();
    mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5 mem_req while stalled", W'(mem_req), W'(1));
      check("t5 mem_addr while stalled", W'(mem_addr), W'(64'h0));
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    #1;
    check("t5 mem_addr after grant", W'(mem_addr), W'(64'h4));

    // PC wrap on the second instance
    do_reset();
    lat_lo = 1; lat_hi = 1;
    mem_gnt = 1'b1;
    #1;
    check("t6 addr 0", W'(mem_addr_w), W'(64'hFFFF_FFFF_FFFF_FFF8));
    tick();
    check("t6 addr 1", W'(mem_addr_w), W'(64'hFFFF_FFFF_FFFF_FFFC));
    tick();
    check("t6 addr 2", W'(mem_addr_w), W'(64'h0));
    tick();
    check("t6 addr 3", W'(mem_addr_w), W'(64'h4));
    instr_ready_w = 1'b1;
    repeat (8) tick();

    // randomised traffic on the main instance
    do_reset();
    lat_lo = 4; lat_hi = 1;
    for (int i = 0; i < 400; i++) begin
      mem_gnt = ($urandom_range(0, 3) != 0);
      instr_ready = $urandom_range(0, 1) == 1;
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = {$urandom, $urandom};
      #1;
      if (fifo_count > 3'd4) check("rand fifo_count bound", W'(fifo_count), W'(4));
      tick();
    end
    redirect_valid = 1'b0;
    mem_gnt = 1'b0;
    instr_ready = 1'b1;
    repeat (20) tick();
    #1;
    check("rand drain all delivered", W'(exp_q.size()), W'(0));
    check("rand drain fifo_count", W'(fifo_count), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
